aes_block_driver: RTL and testbench
===================================

# aes_block_driver

Initiator-side controller for the AES core's init/data/key/mode/valid interface. Accepts 128-bit blocks over a valid/ready stream, issues one core init per block with data, key and mode held stable, captures the core's result pulse, and presents it on a valid/ready output stream. Adds a completion watchdog and, optionally, CBC chaining, so upstream stream logic never handles core sequencing directly.

## Interface
- TIMEOUT_CYCLES, default 64: maximum WAIT cycles before a block is abandoned; legal range 2..65535.
- clk_in  input  1  clock, all logic on rising edge.
- rst_in  input  1  asynchronous, active-low reset.
- key_in  input  128  key; sampled into the key register when key_load_in=1.
- key_load_in  input  1  load key; ignored unless state is IDLE.
- iv_in  input  128  CBC initial vector; sampled at the first block of a message.
- s_valid_in / s_ready_out  in/out  1  input-block handshake.
- s_data_in  input  128  plaintext (encrypt) or ciphertext (decrypt).
- s_mode_in  input  1  1=encrypt, 0=decrypt; sampled with the block.
- s_last_in  input  1  last block of a message; restarts the chain afterward.
- m_valid_out / m_ready_in  out/in  1  result handshake.
- m_data_out  output  128  result block.
- core_init_out  output  1  one-cycle init pulse to the core.
- core_mode_out, core_data_out[127:0], core_key_out[127:0]  output  core operands, registered.
- core_data_in  input  128  core result.
- core_valid_in  input  1  core result strobe.
- busy_out  output  1  state is not IDLE.
- timeout_out  output  1  sticky watchdog error.
- clear_err_in  input  1  clears timeout_out.

## Operation
- States: IDLE, ISSUE, WAIT, OUT.
- IDLE: s_ready_out=1. When s_valid_in=1, latch the operands, mode and last flag, then go to ISSUE. If key_load_in and s_valid_in are both asserted in the same cycle, the key loads first and the block uses the new key.
- ISSUE: core_init_out=1 for exactly one cycle, clear the watchdog, go to WAIT.
- WAIT: core_* outputs stay stable. On core_valid_in, capture the result into m_data_out and go to OUT.
- WAIT timeout: if the watchdog reaches TIMEOUT_CYCLES-1 with no core_valid_in, set timeout_out, drop the block, mark the next block as first-of-message, and return to IDLE. core_valid_in in that same final cycle wins and no timeout is raised.
- OUT: m_valid_out=1 and m_data_out is stable until m_ready_in. On the transfer, go to IDLE.
- s_ready_out=0 in every state except IDLE, so only one block is in flight.
- core_valid_in outside WAIT is ignored.
- clear_err_in clears timeout_out. If clear_err_in and a new timeout occur in the same cycle, timeout_out ends set.
- All datapath logic is bitwise XOR or copy. There is no arithmetic except the watchdog counter, which is 16 bits and saturates.

## Timing
- Reset values: s_ready_out=0 while reset is asserted and 1 from the first clock after release; all other outputs 0. The key register, chain register and counter reset to 0, and the first-of-message flag resets to 1.
- Reset asserted mid-block returns to IDLE immediately. A core result arriving later is ignored.
- Latency: s transfer at edge N gives core_init_out high in cycle N+1. core_valid_in in cycle M gives m_valid_out from cycle M+1.
- Throughput: one block per (core latency + 3) cycles, assuming m_ready_in is held high.

## Configuration
- AES_DRIVER_CBC_EN defined:
  - Chain register C is loaded from iv_in when the block is first-of-message.
  - Encrypt: core_data_out = s_data ^ C; output = result; C <= result.
  - Decrypt: core_data_out = s_data; output = result ^ C; C <= the input ciphertext.
  - A block with s_last_in=1 sets first-of-message for the next block.
- AES_DRIVER_CBC_EN undefined: ECB operation. iv_in and s_last_in are ignored, C is absent, and core_data_out = s_data, output = result. Port list is unchanged.

## Test plan
- ECB encrypt, FIPS-197 C.1: key 000102030405060708090a0b0c0d0e0f, data 00112233445566778899aabbccddeeff -> m_data_out 69c4e0d86a7b0430d8cdb78070b4c55a; exactly one core_init_out pulse.
- ECB decrypt of 69c4e0d86a7b0430d8cdb78070b4c55a with the same key -> 00112233445566778899aabbccddeeff.
- CBC encrypt, SP800-38A F.2.1, two blocks with s_last_in on block 2: key 2b7e151628aed2a6abf7158809cf4f3c, IV 000102030405060708090a0b0c0d0e0f, P1 6bc1bee22e409f96e93d7e117393172a -> C1 7649abac8119b246cee98e9b12e9197d, P2 ae2d8a571e03ac9c9eb76fac45af8e51 -> C2 5086cb9b507219ee95db113a917678b2. Then decrypt C1, C2 back to P1, P2.
- Core model stalls with no core_valid_in and TIMEOUT_CYCLES=8 -> timeout_out rises 8 cycles after core_init_out, state returns to IDLE, and the next block gets the correct result.
- Backpressure: m_ready_in held low for 20 cycles -> m_valid_out and m_data_out are stable and s_ready_out=0 throughout; a spurious core_valid_in during OUT has no effect.
- Reset asserted in WAIT -> all outputs 0 asynchronously; after release, a fresh block completes normally and a stale core_valid_in is ignored.

Source files
------------

// File: rtl/aes_block_driver.sv
// Initiator-side sequencer for the AES core: one block in flight, completion watchdog.
// Define AES_DRIVER_CBC_EN to enable CBC chaining; the default build is ECB.
module aes_block_driver #(
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic         clk_in,
  input  logic         rst_in,
  input  logic [127:0] key_in,
  input  logic         key_load_in,
  input  logic [127:0] iv_in,
  input  logic         s_valid_in,
  output logic         s_ready_out,
  input  logic [127:0] s_data_in,
  input  logic         s_mode_in,
  input  logic         s_last_in,
  output logic         m_valid_out,
  input  logic         m_ready_in,
  output logic [127:0] m_data_out,
  output logic         core_init_out,
  output logic         core_mode_out,
  output logic [127:0] core_data_out,
  output logic [127:0] core_key_out,
  input  logic [127:0] core_data_in,
  input  logic         core_valid_in,
  output logic         busy_out,
  output logic         timeout_out,
  input  logic         clear_err_in
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, OUT} state_e;

  localparam logic [15:0] WDOG_LIMIT = 16'(TIMEOUT_CYCLES - 1);

  state_e       state_q, state_d;
  logic         live_q;
  logic [127:0] key_q, key_d;
  logic [127:0] cdata_q, cdata_d;
  logic [127:0] ckey_q, ckey_d;
  logic         cmode_q, cmode_d;
  logic [127:0] mdata_q, mdata_d;
  logic [15:0]  wdog_q, wdog_d;
  logic         timeout_q, timeout_d;
  logic         accept, expire;

`ifdef AES_DRIVER_CBC_EN
  logic [127:0] chain_q, chain_d;
  logic         first_q, first_d;
  logic [127:0] chain_sel;
  assign chain_sel = first_q ? iv_in : chain_q;
`else
  logic unused_cbc;
  assign unused_cbc = ^{iv_in, s_last_in};
`endif

  // live_q holds s_ready_out low until the first clock after reset release
  assign accept = (state_q == IDLE) && live_q && s_valid_in;
  assign expire = (state_q == WAIT) && !core_valid_in && (wdog_q >= WDOG_LIMIT);

  always_comb begin
    state_d       = state_q;
    key_d         = key_q;
    cdata_d       = cdata_q;
    ckey_d        = ckey_q;
    cmode_d       = cmode_q;
    mdata_d       = mdata_q;
    wdog_d        = wdog_q;
    core_init_out = 1'b0;
    timeout_d     = (timeout_q && !clear_err_in) || expire;
`ifdef AES_DRIVER_CBC_EN
    chain_d       = chain_q;
    first_d       = first_q;
`endif
    case (state_q)
      IDLE: begin
        if (key_load_in) key_d = key_in;
        if (accept) begin
          ckey_d  = key_load_in ? key_in : key_q;
          cmode_d = s_mode_in;
`ifdef AES_DRIVER_CBC_EN
          cdata_d = s_mode_in ? (s_data_in ^ chain_sel) : s_data_in;
          chain_d = chain_sel;
          first_d = s_last_in;
`else
          cdata_d = s_data_in;
`endif
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        core_init_out = 1'b1;
        wdog_d        = '0;
        state_d       = WAIT;
      end
      WAIT: begin
        if (core_valid_in) begin
`ifdef AES_DRIVER_CBC_EN
          // chain_q holds the IV/previous block selected at accept time
          if (cmode_q) begin
            mdata_d = core_data_in;
            chain_d = core_data_in;
          end else begin
            mdata_d = core_data_in ^ chain_q;
            chain_d = cdata_q;
          end
`else
          mdata_d = core_data_in;
`endif
          state_d = OUT;
        end else if (expire) begin
`ifdef AES_DRIVER_CBC_EN
          first_d = 1'b1;
`endif
          state_d = IDLE;
        end else if (wdog_q != '1) begin
          wdog_d = wdog_q + 16'd1;
        end
      end
      OUT: begin
        if (m_ready_in) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q   <= IDLE;
      live_q    <= 1'b0;
      key_q     <= '0;
      cdata_q   <= '0;
      ckey_q    <= '0;
      cmode_q   <= 1'b0;
      mdata_q   <= '0;
      wdog_q    <= '0;
      timeout_q <= 1'b0;
`ifdef AES_DRIVER_CBC_EN
      chain_q   <= '0;
      first_q   <= 1'b1;
`endif
    end else begin
      state_q   <= state_d;
      live_q    <= 1'b1;
      key_q     <= key_d;
      cdata_q   <= cdata_d;
      ckey_q    <= ckey_d;
      cmode_q   <= cmode_d;
      mdata_q   <= mdata_d;
      wdog_q    <= wdog_d;
      timeout_q <= timeout_d;
`ifdef AES_DRIVER_CBC_EN
      chain_q   <= chain_d;
      first_q   <= first_d;
`endif
    end
  end

  assign s_ready_out   = (state_q == IDLE) && live_q;
  assign busy_out      = (state_q != IDLE);
  assign m_valid_out   = (state_q == OUT);
  assign m_data_out    = mdata_q;
  assign core_mode_out = cmode_q;
  assign core_data_out = cdata_q;
  assign core_key_out  = ckey_q;
  assign timeout_out   = timeout_q;

endmodule

// File: tb/tb_aes_block_driver.sv
// Bench for aes_block_driver: vector table, randomized blocks against a
// message-level model, watchdog, backpressure and reset corner cases.
module tb_aes_block_driver;

  localparam int unsigned TO = 8;

  logic         clk_in = 1'b0;
  logic         rst_in = 1'b1;
  logic [127:0] key_in = '0;
  logic         key_load_in = 1'b0;
  logic [127:0] iv_in = '0;
  logic         s_valid_in = 1'b0;
  logic         s_ready_out;
  logic [127:0] s_data_in = '0;
  logic         s_mode_in = 1'b0;
  logic         s_last_in = 1'b0;
  logic         m_valid_out;
  logic         m_ready_in = 1'b0;
  logic [127:0] m_data_out;
  logic         core_init_out;
  logic         core_mode_out;
  logic [127:0] core_data_out;
  logic [127:0] core_key_out;
  logic [127:0] core_data_in = '0;
  logic         core_valid_in = 1'b0;
  logic         busy_out;
  logic         timeout_out;
  logic         clear_err_in = 1'b0;

  always #5 clk_in = ~clk_in;

  aes_block_driver #(.TIMEOUT_CYCLES(TO)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .key_in(key_in), .key_load_in(key_load_in),
    .iv_in(iv_in), .s_valid_in(s_valid_in), .s_ready_out(s_ready_out),
    .s_data_in(s_data_in), .s_mode_in(s_mode_in), .s_last_in(s_last_in),
    .m_valid_out(m_valid_out), .m_ready_in(m_ready_in), .m_data_out(m_data_out),
    .core_init_out(core_init_out), .core_mode_out(core_mode_out),
    .core_data_out(core_data_out), .core_key_out(core_key_out),
    .core_data_in(core_data_in), .core_valid_in(core_valid_in),
    .busy_out(busy_out), .timeout_out(timeout_out), .clear_err_in(clear_err_in)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Core stand-in: known AES pairs from the published vectors, else an invertible mix.
  typedef struct { logic mode; logic [127:0] key; logic [127:0] din; logic [127:0] dout; } kv_t;
  kv_t kv[$];

  function automatic logic [127:0] core_f(input logic mode, input logic [127:0] k, input logic [127:0] d);
    logic [127:0] t;
    foreach (kv[i]) if (kv[i].mode == mode && kv[i].key == k && kv[i].din == d) return kv[i].dout;
    if (mode) begin
      t = {d[63:0], d[127:64]} ^ k;
    end else begin
      t = d ^ k;
      t = {t[63:0], t[127:64]};
    end
    return t;
  endfunction

  int           cyc = 0;
  int           core_lat = 1;
  bit           stall = 0;
  bit           pend = 0;
  int           pend_cnt = 0;
  logic [127:0] pend_res = '0;
  int           inits = 0;

  task automatic step();
    @(posedge clk_in);
    #1;
    cyc++;
    core_valid_in = 1'b0;
    if (pend) begin
      pend_cnt--;
      if (pend_cnt == 0) begin
        core_valid_in = 1'b1;
        core_data_in  = pend_res;
        pend          = 0;
      end
    end
    if (core_init_out) begin
      inits++;
      if (!stall) begin
        pend     = 1;
        pend_cnt = core_lat;
        pend_res = core_f(core_mode_out, core_key_out, core_data_out);
      end
    end
  endtask

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Message-level reference model
  logic [127:0] m_key;
  logic [127:0] m_chain;
  logic         m_first;

  task automatic model_reset();
    m_key = '0; m_chain = '0; m_first = 1'b1;
  endtask

  task automatic model_block(input logic mode, input logic [127:0] data, input logic keyload,
                             input logic [127:0] key, input logic [127:0] iv, input logic last,
                             output logic [127:0] e_cdata, output logic [127:0] e_key,
                             output logic [127:0] e_out);
    logic [127:0] c;
    if (keyload) m_key = key;
    e_key = m_key;
`ifdef AES_DRIVER_CBC_EN
    c = m_first ? iv : m_chain;
    if (mode) begin
      e_cdata = data ^ c;
      e_out   = core_f(1'b1, m_key, e_cdata);
      m_chain = e_out;
    end else begin
      e_cdata = data;
      e_out   = core_f(1'b0, m_key, data) ^ c;
      m_chain = data;
    end
    m_first = last;
`else
    c = iv ^ {127'b0, last};
    e_cdata = data;
    e_out   = core_f(mode, m_key, data);
`endif
  endtask

  task automatic wait_ready();
    int n;
    n = 0;
    while (!s_ready_out && n < 50) begin step(); n++; end
    check("ready_wait", s_ready_out, 1);
  endtask

  task automatic send(input logic mode, input logic [127:0] data, input logic keyload,
                      input logic [127:0] key, input logic [127:0] iv, input logic last,
                      input int hold, output logic [127:0] got);
    logic [127:0] e_cdata, e_key, e_out;
    int i0, cv_cyc, n;
    wait_ready();
    s_valid_in = 1'b1; s_data_in = data; s_mode_in = mode; s_last_in = last;
    key_load_in = keyload; key_in = key; iv_in = iv;
    model_block(mode, data, keyload, key, iv, last, e_cdata, e_key, e_out);
    i0 = inits;
    step();
    s_valid_in = 1'b0; key_load_in = 1'b0;
    s_data_in = rand128(); key_in = rand128(); iv_in = rand128(); s_mode_in = ~mode;
    check("init_pulse", {core_init_out, s_ready_out, busy_out}, 3'b101);
    check("core_data", core_data_out, e_cdata);
    check("core_key", core_key_out, e_key);
    check("core_mode", core_mode_out, mode);
    cv_cyc = -10; n = 0;
    while (!m_valid_out && n < 200) begin
      step(); n++;
      if (core_valid_in) cv_cyc = cyc;
      check("operands_stable", {core_mode_out, core_data_out ^ core_key_out},
            {mode, e_cdata ^ e_key});
    end
    check("m_valid_arrives", m_valid_out, 1);
    check("m_valid_latency", cyc, cv_cyc + 1);
    check("init_count", inits - i0, 1);
    check("m_data", m_data_out, e_out);
    got = m_data_out;
    for (int i = 0; i < hold; i++) begin
      if (hold > 5 && i == hold / 2) begin
        core_valid_in = 1'b1;
        core_data_in  = ~e_out;
      end
      step();
      check("backpressure_hold", {m_valid_out, s_ready_out, busy_out, m_data_out},
            {3'b101, e_out});
    end
    m_ready_in = 1'b1;
    step();
    m_ready_in = 1'b0;
    check("after_transfer", {m_valid_out, s_ready_out, busy_out}, 3'b010);
  endtask

  task automatic stalled_block(input logic clear_last);
    logic pre;
    logic [127:0] k;
    stall = 1;
    wait_ready();
    pre = timeout_out;
    k = rand128();
    s_valid_in = 1'b1; s_data_in = rand128(); s_mode_in = 1'b1; s_last_in = 1'b0;
    key_load_in = 1'b1; key_in = k; iv_in = rand128();
    m_key = k; m_first = 1'b1;
    step();
    s_valid_in = 1'b0; key_load_in = 1'b0;
    check("stall_init", core_init_out, 1);
    for (int i = 0; i < int'(TO); i++) begin
      step();
      check("stall_waiting", {busy_out, m_valid_out, timeout_out}, {2'b10, pre});
    end
    clear_err_in = clear_last;
    step();
    clear_err_in = 1'b0;
    check("timeout_raised", timeout_out, 1);
    check("timeout_idle", {busy_out, s_ready_out, m_valid_out}, 3'b010);
    stall = 0;
  endtask

  typedef struct {
    logic mode; logic keyload; logic [127:0] key; logic [127:0] iv;
    logic [127:0] data; logic last; logic [127:0] exp;
  } vec_t;
  vec_t tbl[$];

  localparam logic [127:0] K0  = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] P0  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C0  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] K1  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] IV  = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] P1  = 128'h6bc1bee22e409f96e93d7e117393172a;
  localparam logic [127:0] C1  = 128'h7649abac8119b246cee98e9b12e9197d;
  localparam logic [127:0] P2  = 128'hae2d8a571e03ac9c9eb76fac45af8e51;
  localparam logic [127:0] C2  = 128'h5086cb9b507219ee95db113a917678b2;
  localparam logic [127:0] X1  = 128'h6bc0bce12a459991e134741a7f9e1925;
  localparam logic [127:0] X2  = 128'hd86421fb9f1a1eda505ee1375746972c;

  initial begin
    logic [127:0] got;
    kv.push_back('{1'b1, K0, P0, C0});
    kv.push_back('{1'b0, K0, C0, P0});
    kv.push_back('{1'b1, K1, X1, C1});
    kv.push_back('{1'b1, K1, X2, C2});
    kv.push_back('{1'b0, K1, C1, X1});
    kv.push_back('{1'b0, K1, C2, X2});

    tbl.push_back('{1'b1, 1'b1, K0, 128'h0, P0, 1'b1, C0});
    tbl.push_back('{1'b0, 1'b0, 128'h0, 128'h0, C0, 1'b1, P0});
`ifdef AES_DRIVER_CBC_EN
    tbl.push_back('{1'b1, 1'b1, K1, IV, P1, 1'b0, C1});
    tbl.push_back('{1'b1, 1'b0, 128'h0, 128'hdeadbeefdeadbeefdeadbeefdeadbeef, P2, 1'b1, C2});
    tbl.push_back('{1'b0, 1'b0, 128'h0, IV, C1, 1'b0, P1});
    tbl.push_back('{1'b0, 1'b0, 128'h0, 128'h0123456789abcdef0123456789abcdef, C2, 1'b1, P2});
`endif

    // Power-on reset
    #2 rst_in = 1'b0;
    #1;
    check("reset_ctrl", {s_ready_out, m_valid_out, core_init_out, core_mode_out, busy_out, timeout_out}, 6'b0);
    check("reset_mdata", m_data_out, 0);
    check("reset_cdata", core_data_out, 0);
    check("reset_ckey", core_key_out, 0);
    step(); step();
    check("reset_hold_ready", s_ready_out, 0);
    rst_in = 1'b1;
    check("ready_before_clock", s_ready_out, 0);
    step();
    check("ready_after_release", {s_ready_out, busy_out}, 2'b10);
    model_reset();

    // Published vectors
    for (int i = 0; i < tbl.size(); i++) begin
      core_lat = 2 + i;
      send(tbl[i].mode, tbl[i].data, tbl[i].keyload, tbl[i].key, tbl[i].iv, tbl[i].last, 0, got);
      check($sformatf("vector_%0d", i), got, tbl[i].exp);
    end

    // Randomized blocks
    for (int i = 0; i < 30; i++) begin
      core_lat = int'($urandom_range(1, 5));
      send($urandom_range(0, 1) == 1, rand128(), $urandom_range(0, 3) == 0, rand128(), rand128(),
           $urandom_range(0, 3) == 0, int'($urandom_range(0, 2)), got);
    end

    // Result in the last watchdog cycle beats the timeout
    core_lat = int'(TO);
    send(1'b1, rand128(), 1'b0, '0, rand128(), 1'b0, 0, got);
    check("last_cycle_no_timeout", timeout_out, 0);

    // Watchdog expiry, recovery, clear/set collision, clear
    stalled_block(1'b0);
    core_lat = 3;
    send(1'b1, P1, 1'b1, K1, IV, 1'b0, 0, got);
`ifdef AES_DRIVER_CBC_EN
    check("recover_first_of_msg", got, C1);
`endif
    check("timeout_sticky", timeout_out, 1);
    stalled_block(1'b1);
    clear_err_in = 1'b1;
    step();
    clear_err_in = 1'b0;
    check("timeout_cleared", timeout_out, 0);

    // Backpressure with a spurious core strobe during OUT
    core_lat = 3;
    send(1'b0, rand128(), 1'b1, rand128(), rand128(), 1'b1, 20, got);

    // Reset while waiting on the core
    stall = 1;
    wait_ready();
    s_valid_in = 1'b1; s_data_in = rand128(); s_mode_in = 1'b1; key_load_in = 1'b1; key_in = rand128();
    step();
    s_valid_in = 1'b0; key_load_in = 1'b0;
    step(); step();
    check("pre_reset_busy", busy_out, 1);
    #2 rst_in = 1'b0;
    #1;
    check("midreset_ctrl", {s_ready_out, m_valid_out, core_init_out, core_mode_out, busy_out, timeout_out}, 6'b0);
    check("midreset_mdata", m_data_out, 0);
    check("midreset_cdata", core_data_out, 0);
    check("midreset_ckey", core_key_out, 0);
    model_reset();
    pend = 0;
    stall = 0;
    step();
    rst_in = 1'b1;
    step();
    core_valid_in = 1'b1;
    core_data_in  = rand128();
    step();
    check("stale_result_ignored", {m_valid_out, busy_out, s_ready_out}, 3'b001);
    core_lat = 2;
    send(1'b1, rand128(), 1'b0, '0, rand128(), 1'b1, 0, got);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_time_limit: got expired expected done");
    $fatal(1);
  end

endmodule
